// File: rtl/prio_req_pkg.sv
// prio_req_pkg: shared constants, FSM state encoding and code helpers for
// the prio_req_ctrl request front-end.
//   CODE_*       : 3-bit service codes presented on o_pcode
//   state_t      : service FSM states
//   idx_to_code  : line index (0..3) -> presented code
//   highest_idx  : index of the highest set bit of a 4-bit vector
package prio_req_pkg;

    localparam logic [2:0] CODE_L3   = 3'b100;
    localparam logic [2:0] CODE_L2   = 3'b011;
    localparam logic [2:0] CODE_L1   = 3'b010;
    localparam logic [2:0] CODE_L0   = 3'b001;
    localparam logic [2:0] CODE_NONE = 3'b000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    function automatic logic [2:0] idx_to_code(input logic [1:0] idx);
        logic [2:0] code;
        case (idx)
            2'd3:    code = CODE_L3;
            2'd2:    code = CODE_L2;
            2'd1:    code = CODE_L1;
            default: code = CODE_L0;
        endcase
        return code;
    endfunction

    // Result is meaningless when v == 0; callers check for that first.
    function automatic logic [1:0] highest_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        else           idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/req_sync_edge.sv
// req_sync_edge: SYNC_STAGES-flop synchroniser for one asynchronous request
// line, followed by rising-edge (EDGE_MODE=1) or level (EDGE_MODE=0) detect.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_async : asynchronous request line
//   o_set   : one-cycle set strobe for the pending bit (edge mode) or the
//             synchronised level (level mode)
module req_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_set
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= s;
        end
    end

    // prev resets to 0, so a line already high at reset release yields one rise.
    assign o_set = EDGE_MODE ? (s & ~prev_q) : s;

endmodule

// File: rtl/prio_req_ctrl.sv
// prio_req_ctrl: synchronises four request lines into sticky pending bits and
// presents the highest-priority enabled one as a 3-bit code with valid/ack.
// Handshake: o_valid rises with a stable o_pcode; the grant is held until a
// cycle with i_ack=1 is sampled while o_valid=1, at which edge the served
// pending bit clears and o_valid drops. i_ack with o_valid=0 is ignored.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req[3:0]   : asynchronous request lines, bit 3 highest priority
//   i_mask[3:0]  : per-line service enable
//   i_ack        : consumer acknowledge
//   o_valid      : o_pcode holds a presented request
//   o_pcode[2:0] : code of the served line, 000 when idle
//   o_pending    : raw pending bits (mask not applied)
module prio_req_ctrl
    import prio_req_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic [3:0] i_mask,
    input  logic       i_ack,
    output logic       o_valid,
    output logic [2:0] o_pcode,
    output logic [3:0] o_pending
);

    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [1:0] sel_idx;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] srv_idx_q, srv_idx_d;
    logic [2:0] pcode_q, pcode_d;
    logic       valid_q, valid_d;

    for (genvar g = 0; g < 4; g++) begin : g_line
        req_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_sync (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_async(i_req[g]),
            .o_set  (set[g])
        );
    end

    assign eligible = pending_q & i_mask;
    assign sel_idx  = highest_idx(eligible);

    always_comb begin
        state_d   = state_q;
        srv_idx_d = srv_idx_q;
        pcode_d   = pcode_q;
        valid_d   = valid_q;
        clr       = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (eligible != 4'b0000) begin
                    srv_idx_d = sel_idx;
                    pcode_d   = idx_to_code(sel_idx);
                    valid_d   = 1'b1;
                    state_d   = ST_PRESENT;
                end else begin
                    pcode_d = CODE_NONE;
                    valid_d = 1'b0;
                end
            end
            ST_PRESENT: begin
                // Grant is frozen here: new requests and mask changes wait.
                if (i_ack) begin
                    clr     = 4'b0001 << srv_idx_q;
                    pcode_d = CODE_NONE;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcode_d = CODE_NONE;
                valid_d = 1'b0;
            end
        endcase
        // Set wins over clear so a re-request in the ack cycle is not lost.
        pending_d = (pending_q & ~clr) | set;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            srv_idx_q <= 2'd0;
            pcode_q   <= CODE_NONE;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            srv_idx_q <= srv_idx_d;
            pcode_q   <= pcode_d;
            valid_q   <= valid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_pcode   = pcode_q;
    assign o_pending = pending_q;

endmodule
